// File: rtl/ic_fifo_pkg.sv
// Shared helpers for the ic_sync_fifo slice: width math and read-mode encodings.
package ic_fifo_pkg;

  localparam int FIFO_MODE_NORMAL    = 0;
  localparam int FIFO_MODE_SHOWAHEAD = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ic_sync_fifo_if.sv
// FIFO bus: write/read requests toward the buffer, data and status flags back.
interface ic_sync_fifo_if
  import ic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);

  logic [DATA_WIDTH-1:0]   data;
  logic                    wrreq;
  logic                    rdreq;
  logic [DATA_WIDTH-1:0]   q;
  logic                    empty;
  logic                    full;
  logic                    almost_full;
  logic                    almost_empty;
  logic [clog2(DEPTH):0]   usedw;
  logic                    ovf_err;
  logic                    udf_err;

  modport master (
    output data, wrreq, rdreq,
    input  q, empty, full, almost_full, almost_empty, usedw, ovf_err, udf_err
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, empty, full, almost_full, almost_empty, usedw, ovf_err, udf_err
  );

endinterface

// File: rtl/ic_sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Zero-latency read; no flow control of its own, the owner gates the write enable.
module ic_sync_fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdat,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/ic_sync_fifo.sv
// Single-clock elastic buffer; q lags rdreq by 1 cycle (normal) or shows the head (show-ahead).
// Back-pressure via full/empty; requests against them are dropped and latch sticky error flags.
module ic_sync_fifo
  import ic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int SHOWAHEAD  = FIFO_MODE_NORMAL,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic           clock,
  input  logic           sclr,
  ic_sync_fifo_if.slave  fifo
);

  localparam int AW = clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam logic [UW-1:0] AF_U   = UW'(AF_THRESH);
  localparam logic [UW-1:0] AE_U   = UW'(AE_THRESH);
  localparam logic [UW-1:0] FULL_U = UW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ic_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("ic_sync_fifo: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 1 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("ic_sync_fifo: AE_THRESH must lie in 1..DEPTH");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [UW-1:0]         usedw_r;
  logic                  ovf_r;
  logic                  udf_r;
  logic                  empty;
  logic                  full;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_dat;

  // Flags decode only the registered count, so no request-to-flag path exists.
  assign empty = (usedw_r == '0);
  assign full  = (usedw_r == FULL_U);
  assign wr_en = fifo.wrreq & ~full;
  assign rd_en = fifo.rdreq & ~empty;

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   usedw_r <= usedw_r + UW'(1);
        2'b01:   usedw_r <= usedw_r - UW'(1);
        default: usedw_r <= usedw_r;
      endcase
      if (fifo.wrreq && full)  ovf_r <= 1'b1;
      if (fifo.rdreq && empty) udf_r <= 1'b1;
    end
  end

  ic_sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clock (clock),
    .we    (wr_en & ~sclr),
    .waddr (wr_ptr),
    .wdat  (fifo.data),
    .raddr (rd_ptr),
    .rdat  (rd_dat)
  );

  if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) begin : g_showahead
    assign fifo.q = rd_dat;
  end else begin : g_normal
    logic [DATA_WIDTH-1:0] q_r;
    always_ff @(posedge clock) begin
      if (sclr)       q_r <= '0;
      else if (rd_en) q_r <= rd_dat;
    end
    assign fifo.q = q_r;
  end

  assign fifo.empty        = empty;
  assign fifo.full         = full;
  assign fifo.almost_full  = (usedw_r >= AF_U);
  assign fifo.almost_empty = (usedw_r < AE_U);
  assign fifo.usedw        = usedw_r;
  assign fifo.ovf_err      = ovf_r;
  assign fifo.udf_err      = udf_r;

endmodule
